// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - loader FSM state encoding and byte-acceptance helper
package imem_loader_pkg;

    typedef enum logic [3:0] {
        LD_IDLE,
        LD_CNT_HI,
        LD_CNT_LO,
        LD_DATA_HI,
        LD_DATA_LO,
        LD_WRITE,
        LD_CHECK,
        LD_DONE,
        LD_ERROR
    } ld_state_e;

    // States in which the loader presents rx_ready and consumes one byte per transfer.
    function automatic logic accepts_byte(input ld_state_e s);
        return (s == LD_CNT_HI) || (s == LD_CNT_LO) || (s == LD_DATA_HI) ||
               (s == LD_DATA_LO) || (s == LD_CHECK);
    endfunction

endpackage

// File: rtl/imem_loader_byte_pair_asm.sv
// rtl/imem_loader_byte_pair_asm.sv - captures the high byte and presents {hi, current byte} as a word
module imem_loader_byte_pair_asm (
    input  logic        clk,
    input  logic        clear,
    input  logic        hi_en,
    input  logic [7:0]  byte_in,
    output logic [15:0] word_o
);

    logic [7:0] hi_q;
    logic [7:0] hi_d;

    always_comb begin
        hi_d = hi_q;
        if (hi_en) begin
            hi_d = byte_in;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            hi_q <= 8'h00;
        end else begin
            hi_q <= hi_d;
        end
    end

    assign word_o = {hi_q, byte_in};

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader writing 16-bit words into instruction memory
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [15:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt
);

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    ld_state_e         state_q, state_d;
    logic              rx_ready_q, rx_ready_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [15:0]       im_wdata_q, im_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_W:0]   n_q, n_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic        xfer;
    logic        hi_en;
    logic [15:0] pair_word;

    assign xfer  = rx_valid & rx_ready_q;
    // The count high byte and each payload high byte share one capture register.
    assign hi_en = xfer & ((state_q == LD_CNT_HI) | (state_q == LD_DATA_HI));

    imem_loader_byte_pair_asm u_pair (
        .clk     (clk),
        .clear   (clear),
        .hi_en   (hi_en),
        .byte_in (rx_data),
        .word_o  (pair_word)
    );

    always_comb begin
        state_d    = state_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        word_cnt_d = word_cnt_q;
        n_d        = n_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            LD_IDLE, LD_DONE, LD_ERROR: begin
                if (start) begin
                    state_d    = LD_CNT_HI;
                    word_cnt_d = '0;
                    im_addr_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = 8'h00;
`endif
                end
            end
            LD_CNT_HI: begin
                if (xfer) state_d = LD_CNT_LO;
            end
            LD_CNT_LO: begin
                if (xfer) begin
                    if ({1'b0, pair_word} > MAX_WORDS) begin
                        state_d = LD_ERROR;
                    end else begin
                        n_d = pair_word[ADDR_W:0];
                        if (pair_word == 16'h0000) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = LD_CHECK;
`else
                            state_d = LD_DONE;
`endif
                        end else begin
                            state_d = LD_DATA_HI;
                        end
                    end
                end
            end
            LD_DATA_HI: begin
                if (xfer) begin
                    state_d = LD_DATA_LO;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = sum_q + rx_data;
`endif
                end
            end
            LD_DATA_LO: begin
                if (xfer) begin
                    state_d    = LD_WRITE;
                    im_we_d    = 1'b1;
                    im_wdata_d = pair_word;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = sum_q + rx_data;
`endif
                end
            end
            LD_WRITE: begin
                im_addr_d  = im_addr_q + 1'b1;
                word_cnt_d = word_cnt_q + 1'b1;
                if (word_cnt_d == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = LD_CHECK;
`else
                    state_d = LD_DONE;
`endif
                end else begin
                    state_d = LD_DATA_HI;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            LD_CHECK: begin
                if (xfer) state_d = (rx_data == sum_q) ? LD_DONE : LD_ERROR;
            end
`endif
            default: state_d = LD_IDLE;
        endcase

        // Status outputs are registered copies of what the next state implies.
        rx_ready_d = accepts_byte(state_d);
        cpu_hold_d = (state_d != LD_IDLE) && (state_d != LD_DONE);
        done_d     = (state_d == LD_DONE);
        err_d      = (state_d == LD_ERROR);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q    <= LD_IDLE;
            rx_ready_q <= 1'b0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= 16'h0000;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            word_cnt_q <= '0;
            n_q        <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            rx_ready_q <= rx_ready_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
            word_cnt_q <= word_cnt_d;
            n_q        <= n_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign rx_ready = rx_ready_q;
    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              clear, start, rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready, im_we, cpu_hold, done, err;
    logic [ADDR_W-1:0] im_addr;
    logic [15:0]       im_wdata;
    logic [ADDR_W:0]   word_cnt;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .clear    (clear),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err),
        .word_cnt (word_cnt)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    wr_t wr_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    always @(negedge clk) begin
        if (im_we) wr_q.push_back('{im_addr, im_wdata});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 100 && !rx_ready; i++) @(negedge clk);
        if (!rx_ready) begin
            check("rx_ready_timeout", rx_ready, 1);
            rx_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] words[$], input int gap);
        logic [15:0] n;
        logic [7:0]  sum;
        n   = 16'(words.size());
        sum = 8'h00;
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
        foreach (words[i]) begin
            send_byte(words[i][15:8], gap);
            send_byte(words[i][7:0], gap);
            sum = sum + words[i][15:8] + words[i][7:0];
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(sum, gap);
`endif
        rx_valid = 1'b0;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 50 && !(done || err); i++) @(negedge clk);
        check("end_timeout", done | err, 1);
    endtask

    task automatic check_writes(input string tag, input logic [15:0] words[$]);
        int bad;
        bad = 0;
        check({tag, "_nwrites"}, wr_q.size(), words.size());
        foreach (words[i]) begin
            if (i < wr_q.size()) begin
                if (wr_q[i].addr !== ADDR_W'(i) || wr_q[i].data !== words[i]) bad++;
            end
        end
        check({tag, "_bad_writes"}, bad, 0);
    endtask

    logic [15:0] f1[$];
    logic [15:0] big[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        f1 = '{16'h1234, 16'hABCD};
        clear = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(negedge clk);
        clear = 1'b0;
        check("rst_rx_ready", rx_ready, 0);
        check("rst_im_we", im_we, 0);
        check("rst_cpu_hold", cpu_hold, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_im_addr", im_addr, 0);
        check("rst_im_wdata", im_wdata, 0);
        check("rst_word_cnt", word_cnt, 0);

        // 1: back-to-back bytes
        pulse_start();
        check("t1_hold", cpu_hold, 1);
        check("t1_ready", rx_ready, 1);
        wr_q.delete();
        send_frame(f1, 0);
        wait_end();
        check_writes("t1", f1);
        check("t1_done", done, 1);
        check("t1_err", err, 0);
        check("t1_hold_off", cpu_hold, 0);
        check("t1_word_cnt", word_cnt, 2);
        check("t1_ready_off", rx_ready, 0);

        // 2: valid toggling; start from DONE
        pulse_start();
        check("t2_done_clr", done, 0);
        check("t2_hold", cpu_hold, 1);
        wr_q.delete();
        send_frame(f1, 1);
        wait_end();
        check_writes("t2", f1);
        check("t2_done", done, 1);
        check("t2_word_cnt", word_cnt, 2);

`ifdef LOADER_CHECKSUM_EN
        // 3: checksum good and bad
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h10, 0);
        send_byte(8'h20, 0); send_byte(8'h30, 0);
        rx_valid = 1'b0;
        wait_end();
        check("t3_good_done", done, 1);
        check("t3_good_err", err, 0);
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h10, 0);
        send_byte(8'h20, 0); send_byte(8'h31, 0);
        rx_valid = 1'b0;
        wait_end();
        check("t3_bad_err", err, 1);
        check("t3_bad_done", done, 0);
        check("t3_bad_hold", cpu_hold, 1);
`endif

        // 4: oversize count, then exact fill
        pulse_start();
        wr_q.delete();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        rx_valid = 1'b0;
        check("t4_err", err, 1);
        check("t4_done", done, 0);
        check("t4_hold", cpu_hold, 1);
        check("t4_ready", rx_ready, 0);
        repeat (5) @(negedge clk);
        check("t4_no_we", wr_q.size(), 0);
        for (int i = 0; i < 256; i++) big.push_back({8'(i), ~8'(i)});
        pulse_start();
        check("t4_err_clr", err, 0);
        send_frame(big, 0);
        wait_end();
        check_writes("t4_fill", big);
        check("t4_fill_done", done, 1);
        check("t4_fill_addr_wrap", im_addr, 0);
        check("t4_fill_word_cnt", word_cnt, 256);

        // 5: clear mid-load
        pulse_start();
        wr_q.delete();
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'hAB, 0);
        clear = 1'b1; rx_valid = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        check("t5_pre_writes", wr_q.size(), 1);
        check("t5_hold", cpu_hold, 0);
        check("t5_ready", rx_ready, 0);
        check("t5_word_cnt", word_cnt, 0);
        wr_q.delete();
        repeat (10) @(negedge clk);
        check("t5_no_we", wr_q.size(), 0);
        pulse_start();
        f1 = '{16'hCAFE, 16'hF00D, 16'h0001};
        send_frame(f1, 0);
        wait_end();
        check_writes("t5_reload", f1);
        check("t5_done", done, 1);

        // 6: start ignored in DATA_HI, honoured in DONE
        pulse_start();
        wr_q.delete();
        send_byte(8'h00, 1); send_byte(8'h01, 1);
        pulse_start();
        check("t6_ready", rx_ready, 1);
        send_byte(8'h12, 0); send_byte(8'h34, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h46, 0);
`endif
        rx_valid = 1'b0;
        wait_end();
        f1 = '{16'h1234};
        check_writes("t6", f1);
        check("t6_done", done, 1);
        check("t6_err", err, 0);
        pulse_start();
        check("t6_done_clr", done, 0);
        check("t6_hold", cpu_hold, 1);
        check("t6_ready_new", rx_ready, 1);
        wr_q.delete();
        f1 = '{16'hBEEF};
        send_frame(f1, 0);
        wait_end();
        check_writes("t6_new", f1);
        check("t6_new_done", done, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
